// File: rtl/buffer_pkg.sv
// -----------------------------------------------------------------------------
// buffer_pkg
// Shared constants and types for the 64-to-512 bit line packer.
//   LANE_W     : width of one narrow input word
//   LINE_W     : width of one assembled output line
//   LANES      : narrow words per line
//   lane_idx_t : lane index type (selects one of LANES lanes)
// -----------------------------------------------------------------------------
package buffer_pkg;

    localparam int LANE_W = 64;
    localparam int LINE_W = 512;
    localparam int LANES  = 8;

    typedef logic [2:0] lane_idx_t;

    localparam lane_idx_t LAST_LANE = 3'd7;

endpackage

// File: rtl/line_fifo_sc.sv
// -----------------------------------------------------------------------------
// line_fifo_sc
// Single-clock show-ahead FIFO of W-bit lines.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous clear (empties the FIFO, blocks push/pop)
//   push, push_data : enqueue push_data when not full
//   pop          : dequeue head when not empty
//   head         : current head line (valid whenever empty = 0)
//   full, empty  : count == DEPTH / count == 0
//   almost_full  : free entries <= AFULL_MARGIN
//   level        : entries currently stored
// All status outputs decode the registered count only.
// -----------------------------------------------------------------------------
module line_fifo_sc #(
    parameter int W            = 512,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW:0] MARGIN_L = (AW+1)'(AFULL_MARGIN);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   free_cnt;
    logic          push_ok;
    logic          pop_ok;

    // Both full and empty are judged on pre-edge state, so a pop in the
    // same cycle never makes room for a push into a full FIFO.
    assign push_ok = push && !full  && !clr;
    assign pop_ok  = pop  && !empty && !clr;

    assign full        = (count == DEPTH_L);
    assign empty       = (count == '0);
    assign free_cnt    = DEPTH_L - count;
    assign almost_full = (free_cnt <= MARGIN_L);
    assign level       = count;
    assign head        = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Line storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/buffer_64_to_512.sv
// -----------------------------------------------------------------------------
// buffer_64_to_512
// Packs 64-bit words into 512-bit lines (first word in bits 63:0) and queues
// the lines in a show-ahead line FIFO.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear; beats wr_enable/rd_enable
//   data_in, wr_enable : narrow word input
//   flush       : (only with BUFFER_64_TO_512_FLUSH_EN) push a partial line
//   data_out, rd_enable : head line of the FIFO and its pop strobe
//   full, empty, full_n, level : FIFO status (full_n = almost full)
//   overflow    : sticky, set when a write is dropped
// Optional feature macro: BUFFER_64_TO_512_FLUSH_EN.
//
// Handshake: a word is taken at a rising edge when wr_enable=1 and full=0;
// with full=1 it is dropped and overflow sets. A line is removed at a rising
// edge when rd_enable=1 and empty=0; rd_enable with empty=1 is ignored.
// -----------------------------------------------------------------------------
module buffer_64_to_512
    import buffer_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic [LANE_W-1:0]      data_in,
    input  logic                   wr_enable,
`ifdef BUFFER_64_TO_512_FLUSH_EN
    input  logic                   flush,
`endif
    output logic [LINE_W-1:0]      data_out,
    input  logic                   rd_enable,
    output logic                   full,
    output logic                   empty,
    output logic                   full_n,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    lane_idx_t          sel;
    logic [LANE_W-1:0]  lanes [LANES-1];
    logic               wr_accept;
    logic               flush_push;
    logic               push;
    logic [LINE_W-1:0]  line_data;

    assign wr_accept = wr_enable && !full;

`ifdef BUFFER_64_TO_512_FLUSH_EN
    // A flush only has something to push if lanes are pending or a word is
    // being taken this same cycle.
    assign flush_push = flush && !full && ((sel != '0) || wr_accept);
`else
    assign flush_push = 1'b0;
`endif

    assign push = (wr_accept && (sel == LAST_LANE)) || flush_push;

    // Lanes below sel come from storage, lane sel from data_in if a word is
    // taken now, everything above is zero (only visible on a flush).
    always_comb begin
        line_data = '0;
        for (int i = 0; i < LANES - 1; i++) begin
            if (lane_idx_t'(i) < sel) line_data[i*LANE_W +: LANE_W] = lanes[i];
        end
        if (wr_accept) line_data[int'(sel)*LANE_W +: LANE_W] = data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= '0;
        end else if (clr) begin
            sel <= '0;
        end else if (flush_push) begin
            sel <= '0;
        end else if (wr_accept) begin
            sel <= sel + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clr) begin
            overflow <= 1'b0;
        end else if (wr_enable && full) begin
            overflow <= 1'b1;
        end
    end

    // Partial lanes need no reset: sel gates which ones are ever used.
    always_ff @(posedge clk) begin
        if (wr_accept && (sel != LAST_LANE)) lanes[sel] <= data_in;
    end

    line_fifo_sc #(
        .W            (LINE_W),
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (AFULL_MARGIN)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .push        (push),
        .push_data   (line_data),
        .pop         (rd_enable),
        .head        (data_out),
        .full        (full),
        .empty       (empty),
        .almost_full (full_n),
        .level       (level)
    );

endmodule

// File: doc/buffer_64_to_512.md
BUFFER_64_TO_512 -- requirements
Module: buffer_64_to_512

Interface
REQ-001 Parameter: DEPTH, 16, number of 512-bit lines held in the line FIFO (power of two, 4..256).
REQ-002 Parameter: AFULL_MARGIN, 2, free-line count at or below which full_n asserts.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: clr  input  1  synchronous clear, active-high.
REQ-006 Port: data_in  input  64  narrow word to pack.
REQ-007 Port: wr_enable  input  1  data_in valid this cycle.
REQ-008 Port: data_out  output  512  head line of FIFO (show-ahead).
REQ-009 Port: rd_enable  input  1  pop head line.
REQ-010 Port: full  output  1  line FIFO holds DEPTH lines.
REQ-011 Port: empty  output  1  line FIFO holds 0 lines.
REQ-012 Port: full_n  output  1  almost-full: free lines <= AFULL_MARGIN.
REQ-013 Port: overflow  output  1  sticky: a write was dropped.
REQ-014 Port: level  output  $clog2(DEPTH)+1  lines currently stored.

Function
REQ-015 A 3-bit lane counter sel SHALL select the lane; accepted word stored at data bits sel*64+63:sel*64 (first word = bits 63:0).
REQ-016 A write SHALL be accepted when wr_enable=1 and full=0; sel increments per accepted word, wrapping 7->0.
REQ-017 The accepted word at sel=7 SHALL push the assembled line (lanes 0..6 plus data_in) into the FIFO at the same edge.
REQ-018 Latency: line SHALL appear on data_out with empty=0 in the cycle after the edge accepting its 8th word.
REQ-019 data_out SHALL equal the head line whenever empty=0; value when empty=1 is don't-care.
REQ-020 rd_enable with empty=0 SHALL pop the head at the edge; rd_enable with empty=1 SHALL be ignored.
REQ-021 Writes with full=1 SHALL be dropped (sel and lanes unchanged) and overflow SHALL set; full is evaluated before any same-cycle pop.
REQ-022 Simultaneous push and pop with full=0, empty=0 SHALL leave level unchanged.
REQ-023 full, empty, full_n, level SHALL be registered-state decodes, valid every cycle.
REQ-024 clr SHALL take priority over wr_enable/rd_enable: sel=0, FIFO emptied, overflow=0, partial lanes discarded.

Reset
REQ-025 rst_n=0 SHALL asynchronously force sel=0, level=0, empty=1, full=0, full_n=0, overflow=0.
REQ-026 Reset mid-line SHALL discard the partial line; lane storage and FIFO RAM need no reset.

Configuration
REQ-027 With BUFFER_64_TO_512_FLUSH_EN defined, an input port flush (1 bit) SHALL exist; flush=1, full=0, sel!=0 pushes the partial line with unwritten lanes zero and sets sel=0.
REQ-028 With the macro, flush and a same-cycle accepted write SHALL include that word in the pushed line; flush at sel=7 with write is an ordinary push.
REQ-029 With the macro, flush with sel=0 and no write, or with full=1, SHALL be a no-op (no overflow set).
REQ-030 Without the macro, no flush port exists; lines are pushed only after 8 words.

Structure
REQ-031 Package buffer_pkg SHALL hold LANE_W=64, LINE_W=512, LANES=8 and the lane-index typedef.
REQ-032 Sub-module line_fifo_sc SHALL implement the LINE_W-wide show-ahead FIFO with level/full/empty/almost-full; packer logic stays in buffer_64_to_512.

Verification
REQ-033 Write 0x0..0x7 consecutively -> next cycle empty=0, data_out lane k = k, level=1; rd_enable -> empty=1.
REQ-034 Stream 16*8 words with no reads (DEPTH=16) -> full=1 after 128th word, full_n=1 when level>=14; 129th write dropped, overflow=1, sel stays 0.
REQ-035 FIFO level=5, 8th word written with rd_enable=1 same cycle -> level stays 5, head advances.
REQ-036 Write 3 words, assert rst_n=0 mid-cycle -> outputs reset immediately; 8 new words then form one clean line with no stale lanes.
REQ-037 Write 3 words, pulse clr, write 8 words -> exactly one line containing only the post-clr words; overflow=0.
REQ-038 (FLUSH_EN) write 0xA,0xB,0xC then flush -> line lanes 0..2 = A,B,C, lanes 3..7 = 0, sel=0; flush on empty packer -> no line.
